// File: rtl/stack_client.sv
// stack_client: command-side initiator for the stack unit.
//
// Accepts one host command at a time (valid/ready), forwards it to the stack
// with transition signalling on rdy_out/ack_in, and returns the stack's
// dataout/esito through a one-entry response register.
//
// Optional feature macro: STACK_CLIENT_TIMEOUT_EN
//   Defined   - ack watchdog of TIMEOUT_CYCLES cycles in WAIT; rsp_timeout flags
//               a watchdog-generated response.
//   Undefined - WAIT lasts until ack; rsp_timeout is tied to 0.
//
// Ports:
//   clock, reset_n          clock and asynchronous active-low reset
//   cmd_valid/cmd_ready     host command handshake
//   cmd_op/cmd_data/cmd_n   command: 0 PUSH,1 POP,2 SUM,3 SUB,4 MEAN (5-7 illegal)
//   rsp_valid/rsp_ready     host response handshake
//   rsp_data/rsp_esito      stack result (signed, bit-exact) and success flag
//   rsp_timeout             response produced by the watchdog
//   rdy_out                 request line to stack rdy_in (one toggle per request)
//   op_out/data_out/n_out   operation, operand and MEAN count to the stack
//   ack_in                  stack ack (toggles once per completed request)
//   stack_data/stack_esito  stack dataout/esito
//   busy                    high whenever the FSM is not in IDLE
module stack_client #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned N_W            = 10,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [N_W-1:0]    cmd_n,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_esito,
  output logic              rsp_timeout,
  output logic              rdy_out,
  output logic [2:0]        op_out,
  output logic [DATA_W-1:0] data_out,
  output logic [N_W-1:0]    n_out,
  input  logic              ack_in,
  input  logic [DATA_W-1:0] stack_data,
  input  logic              stack_esito,
  output logic              busy
);

  localparam logic [2:0] OpMean = 3'd4;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e state_q;
  logic   ack_match;
  logic   cmd_legal;

  if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("stack_client: TIMEOUT_CYCLES must be at least 1");
  end

  // No request outstanding when the stack's ack level has caught up with ours.
  assign ack_match = (ack_in == rdy_out);
  assign cmd_legal = (cmd_op <= OpMean) && !((cmd_op == OpMean) && (cmd_n == '0));

  // After a watchdog timeout the request is still outstanding, so IDLE must
  // wait for the late ack before accepting anything new.
  assign cmd_ready = (state_q == StIdle) && ack_match;
  assign busy      = (state_q != StIdle);

`ifdef STACK_CLIENT_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] cnt_q;
  logic            timeout_hit;

  assign timeout_hit = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      rdy_out     <= 1'b0;
      op_out      <= '0;
      data_out    <= '0;
      n_out       <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_esito   <= 1'b0;
`ifdef STACK_CLIENT_TIMEOUT_EN
      rsp_timeout <= 1'b0;
      cnt_q       <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid && cmd_ready) begin
            if (cmd_legal) begin
              op_out   <= cmd_op;
              data_out <= cmd_data;
              n_out    <= cmd_n;
              rdy_out  <= ~rdy_out;
`ifdef STACK_CLIENT_TIMEOUT_EN
              cnt_q    <= '0;
`endif
              state_q  <= StWait;
            end else begin
              // Rejected locally: the stack never sees it.
              rsp_data    <= '0;
              rsp_esito   <= 1'b0;
`ifdef STACK_CLIENT_TIMEOUT_EN
              rsp_timeout <= 1'b0;
`endif
              rsp_valid   <= 1'b1;
              state_q     <= StResp;
            end
          end
        end
        StWait: begin
          if (ack_match) begin
            rsp_data    <= stack_data;
            rsp_esito   <= stack_esito;
`ifdef STACK_CLIENT_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
            rsp_valid   <= 1'b1;
            state_q     <= StResp;
`ifdef STACK_CLIENT_TIMEOUT_EN
          end else if (timeout_hit) begin
            // rdy_out stays toggled: the request remains outstanding.
            rsp_data    <= '0;
            rsp_esito   <= 1'b0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            state_q     <= StResp;
          end else begin
            cnt_q <= cnt_q + 1'b1;
`endif
          end
        end
        StResp: begin
          // rsp_valid is always set in RESP, so rsp_ready alone completes it.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/stack_client.md
# stack_client

Command-side initiator for the stack unit. It accepts one host command at a time over a valid/ready interface and drives the stack's level-transition request line (`rdy_in`), `op`, `datain` and `n`. It waits for the stack's `ack` transition, then returns `dataout`/`esito` to the host through a one-entry response register. It sits between any host sequencer and the stack, and shares the stack's clock.

## Interface
- `DATA_W`, 32: data width; matches stack `datain`/`dataout`.
- `N_W`, 10: width of the MEAN operand count `n`.
- `TIMEOUT_CYCLES`, 1024: ack watchdog limit in cycles; used only with `STACK_CLIENT_TIMEOUT_EN`.

Ports:
- `clock`  in  1  the only clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  host command present.
- `cmd_ready`  out  1  client can accept a command.
- `cmd_op`  in  3  0 PUSH, 1 POP, 2 SUM, 3 SUB, 4 MEAN; 5–7 illegal.
- `cmd_data`  in  DATA_W  PUSH operand.
- `cmd_n`  in  N_W  MEAN count.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  host consumes the response.
- `rsp_data`  out  DATA_W  signed result (the stack's `dataout`).
- `rsp_esito`  out  1  1 = success.
- `rsp_timeout`  out  1  response was produced by the watchdog.
- `rdy_out`  out  1  to stack `rdy_in`; each toggle is one request.
- `op_out`  out  3  to stack `op`.
- `data_out`  out  DATA_W  to stack `datain`.
- `n_out`  out  N_W  to stack `n`.
- `ack_in`  in  1  from stack; toggles once per completed request.
- `stack_data`  in  DATA_W  from stack `dataout`.
- `stack_esito`  in  1  from stack `esito`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- **Protocol.** Transition signalling. A request is outstanding while `ack_in != rdy_out`. It completes when `ack_in` equals `rdy_out` again.
- **Reset values.**
  - `rdy_out`, `op_out`, `data_out`, `n_out`, `rsp_*`, `busy` all reset to 0.
  - `cmd_ready` is 1 in IDLE.
  - The stack's `ack` idles equal to `rdy_in` out of reset.
- **FSM.** States are IDLE, WAIT and RESP.
- **IDLE.**
  - `cmd_ready` = 1 only when `ack_in == rdy_out`.
  - On the accept edge (`cmd_valid & cmd_ready`), for a legal command: register `op_out`, `data_out`, `n_out`, toggle `rdy_out`, go to WAIT.
  - Illegal commands (op 5–7, or MEAN with `cmd_n` = 0) are never sent to the stack and `rdy_out` does not toggle. They load `rsp_data` = 0, `rsp_esito` = 0 and go to RESP.
- **WAIT.**
  - `op_out`, `data_out` and `n_out` are held stable.
  - On the first edge that samples `ack_in == rdy_out`: capture `stack_data` and `stack_esito`, set `rsp_valid`, go to RESP.
- **RESP.**
  - `rsp_*` are held.
  - On the edge with `rsp_valid & rsp_ready`: clear `rsp_valid`, go to IDLE.
- **Arithmetic.** The client does none. `rsp_data` is passed through bit-exact and interpreted as signed.
- **Reset mid-operation.** Asynchronous return to IDLE with reset values. Any outstanding request is abandoned; the system resets the stack together with the client.
- **Simultaneous events.** `cmd_valid` is ignored outside IDLE. `rsp_ready` without `rsp_valid` has no effect.

## Timing
- Accept edge to `rdy_out` toggle: the same edge, visible in the next cycle.
- `ack_in` toggle to `rsp_valid`:
  - `rsp_valid` is high in the cycle after the first edge that samples the toggle.
  - Minimum command-to-response latency is 2 cycles when `ack_in` follows within one cycle.
- Illegal command: `rsp_valid` is high the cycle after the accept edge.
- Back-to-back commands: one IDLE cycle minimum between the response handshake and the next accept. Throughput is therefore at most 1 command per 3 cycles.
- `ack_in` must be synchronous to `clock`; the client has no synchronizer.

## Configuration
- Macro: `STACK_CLIENT_TIMEOUT_EN`.
- **Defined.**
  - A counter runs in WAIT. When it reaches `TIMEOUT_CYCLES` without completion, the client loads `rsp_data` = 0, `rsp_esito` = 0, `rsp_timeout` = 1 and goes to RESP.
  - `rdy_out` is not reverted, so the request stays outstanding.
  - IDLE then holds `cmd_ready` low until the late ack arrives; the late ack's data is discarded.
  - The counter clears on every WAIT entry.
- **Undefined.** WAIT lasts indefinitely, `rsp_timeout` is tied to 0, and no counter is built.

## Test plan
- PUSH 1023, then POP, with a stack model returning ack 1 cycle later -> POP response `rsp_data` = 1023, `rsp_esito` = 1; `rdy_out` toggles exactly twice.
- PUSH 500, PUSH 750, SUM, then SUB on a fresh 500/750 stack -> SUM response 1250 and SUB response 250, each with esito 1 and 2-cycle latency.
- MEAN with `cmd_n` = 0, and op = 6 -> both give `rsp_esito` = 0 and `rsp_data` = 0 with no `rdy_out` toggle; MEAN with n = 4 over 1200/300/750/500 -> 687.
- Hold `rsp_ready` low for 5 cycles -> `rsp_*` are stable, `cmd_ready` = 0, and a second `cmd_valid` is not accepted.
- With `STACK_CLIENT_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 16, ack withheld -> response at cycle 16 with timeout = 1 and esito = 0; `cmd_ready` stays 0 until ack toggles at cycle 40, then returns to 1.
- Assert `reset_n` low in mid-WAIT -> all outputs go to 0 immediately, the FSM is in IDLE, and `cmd_ready` = 1 after release.
